// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace buffer: record layout, record kinds and run-control states.
// Record field widths here bound the DATA_W / MADDR_W / CYC_W parameters of the top level.
package cpu_trace_pkg;

    localparam int DROP_W     = 16;
    localparam int REC_DATA_W = 32;
    localparam int REC_IDX_W  = 7;
    localparam int REC_CYC_W  = 16;

    typedef enum logic [1:0] {
        REG   = 2'd0,
        STORE = 2'd1,
        STOP  = 2'd2
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e            kind;
        logic [REC_CYC_W-1:0]   cycle;
        logic [REC_IDX_W-1:0]   idx;
        logic [REC_DATA_W-1:0]  data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MARK = 2'd1,
        DONE = 2'd2
    } run_state_e;

    // Saturating add of 0..2 lost records onto the drop counter.
    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a,
                                                       input logic [1:0] b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + {{(DROP_W-1){1'b0}}, b};
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// First-word-fall-through read port of the trace buffer (valid/ready plus head record fields).
interface cpu_trace_buffer_if #(
    parameter int DATA_W  = 32,
    parameter int MADDR_W = 7,
    parameter int CYC_W   = 16
);
    logic                       valid;
    logic                       ready;
    cpu_trace_pkg::trace_kind_e kind;
    logic [CYC_W-1:0]           cycle;
    logic [MADDR_W-1:0]         idx;
    logic [DATA_W-1:0]          data;

    modport master (output valid, kind, cycle, idx, data, input ready);
    modport slave  (input valid, kind, cycle, idx, data, output ready);
endinterface

// File: rtl/cpu_trace_buffer_fifo.sv
// trace_fifo: DEPTH-entry FIFO of trace records with up to two ordered pushes and one pop per cycle.
// The caller never pushes more records than free_o reports.
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              push_cnt_i,
    input  trace_rec_t              push_a_i,
    input  trace_rec_t              push_b_i,
    input  logic                    pop_i,
    output trace_rec_t              head_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic [$clog2(DEPTH):0]  free_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    trace_rec_t         mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, wptr_b;
    logic [LVL_W-1:0]   level_q, level_d;

    // A slot being popped this cycle is already reusable by this cycle's push.
    always_comb begin
        wptr_b  = wptr_q + PTR_W'(1);
        wptr_d  = wptr_q + PTR_W'(push_cnt_i);
        rptr_d  = rptr_q + PTR_W'(pop_i);
        level_d = level_q + LVL_W'(push_cnt_i) - LVL_W'(pop_i);
        free_o  = LVL_W'(DEPTH) - level_q + LVL_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (push_cnt_i != 2'd0) mem_q[wptr_q] <= push_a_i;
        if (push_cnt_i == 2'd2) mem_q[wptr_b] <= push_b_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: stamps WB register writes and MEM stores, buffers them, halts the CPU after STOP_CYCLES.
// Optional macro TRACE_R0_FILTER_EN suppresses records for writes to r0.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = REC_DATA_W,
    parameter int MADDR_W     = REC_IDX_W,
    parameter int CYC_W       = REC_CYC_W,
    parameter int STOP_CYCLES = 50
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wb_en_i,
    input  logic [4:0]              wb_reg_i,
    input  logic [DATA_W-1:0]       wb_data_i,
    input  logic                    st_en_i,
    input  logic [MADDR_W-1:0]      st_addr_i,
    input  logic [DATA_W-1:0]       st_data_i,
    input  logic [31:0]             pc_i,
    output logic                    run_o,
    cpu_trace_buffer_if.master      rd,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic [DROP_W-1:0]       drop_cnt_o
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    run_state_e         state_q, state_d;
    logic [CYC_W-1:0]   cycle_q, cycle_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic               run_q, run_d;

    logic               reg_ev, st_ev, valid, pop;
    logic [1:0]         n_ev, push_cnt;
    logic [LVL_W-1:0]   level, free;
    trace_rec_t         rec_reg, rec_st, rec_stop, push_a, push_b, head;

`ifdef TRACE_R0_FILTER_EN
    assign reg_ev = wb_en_i & (wb_reg_i != 5'd0);
`else
    assign reg_ev = wb_en_i;
`endif
    assign st_ev = st_en_i;

    assign valid = (level != '0);
    assign pop   = valid & rd.ready;

    always_comb begin
        rec_reg.kind   = REG;
        rec_reg.cycle  = REC_CYC_W'(cycle_q);
        rec_reg.idx    = REC_IDX_W'(wb_reg_i);
        rec_reg.data   = REC_DATA_W'(wb_data_i);
        rec_st.kind    = STORE;
        rec_st.cycle   = REC_CYC_W'(cycle_q);
        rec_st.idx     = REC_IDX_W'(st_addr_i);
        rec_st.data    = REC_DATA_W'(st_data_i);
        rec_stop.kind  = STOP;
        rec_stop.cycle = REC_CYC_W'(STOP_CYCLES);
        rec_stop.idx   = '0;
        rec_stop.data  = REC_DATA_W'(pc_i);
    end

    // Push arbitration: REG is older than STORE, so it wins the last free slot.
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        drop_cnt_d = drop_cnt_q;
        n_ev       = 2'd0;
        push_cnt   = 2'd0;
        push_a     = rec_st;
        push_b     = rec_st;
        case (state_q)
            RUN: begin
                if (cycle_q != {CYC_W{1'b1}}) cycle_d = cycle_q + CYC_W'(1);
                n_ev       = {1'b0, reg_ev} + {1'b0, st_ev};
                push_cnt   = (free >= LVL_W'(n_ev)) ? n_ev : free[1:0];
                push_a     = reg_ev ? rec_reg : rec_st;
                drop_cnt_d = sat_add_drop(drop_cnt_q, n_ev - push_cnt);
                if (STOP_CYCLES != 0 && cycle_q == CYC_W'(STOP_CYCLES)) state_d = MARK;
            end
            MARK: begin
                if (free != '0) begin
                    push_cnt = 2'd1;
                    push_a   = rec_stop;
                    state_d  = DONE;
                end
            end
            default: ;
        endcase
        run_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= RUN;
            cycle_q    <= '0;
            drop_cnt_q <= '0;
            run_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            drop_cnt_q <= drop_cnt_d;
            run_q      <= run_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_cnt_i (push_cnt),
        .push_a_i   (push_a),
        .push_b_i   (push_b),
        .pop_i      (pop),
        .head_o     (head),
        .level_o    (level),
        .free_o     (free)
    );

    // Payload is forced to zero while empty so the read port is clean out of reset.
    assign rd.valid   = valid;
    assign rd.kind    = valid ? head.kind : REG;
    assign rd.cycle   = valid ? CYC_W'(head.cycle) : '0;
    assign rd.idx     = valid ? MADDR_W'(head.idx) : '0;
    assign rd.data    = valid ? DATA_W'(head.data) : '0;

    assign run_o      = run_q;
    assign level_o    = level;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer (default DEPTH=16, STOP_CYCLES=50).
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        st_en;
    logic [6:0]  st_addr;
    logic [31:0] st_data;
    logic [31:0] pc;
    logic        run;
    logic [4:0]  level;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    localparam logic [31:0] PC_VAL = 32'h1234_5678;

    cpu_trace_buffer_if #(.DATA_W(32), .MADDR_W(7), .CYC_W(16)) rd_if ();

    cpu_trace_buffer #(.DEPTH(16), .DATA_W(32), .MADDR_W(7), .CYC_W(16), .STOP_CYCLES(50)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_en_i    (wb_en),
        .wb_reg_i   (wb_reg),
        .wb_data_i  (wb_data),
        .st_en_i    (st_en),
        .st_addr_i  (st_addr),
        .st_data_i  (st_data),
        .pc_i       (pc),
        .run_o      (run),
        .rd         (rd_if),
        .level_o    (level),
        .drop_cnt_o (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_events();
        wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        st_en = 1'b0; st_addr = '0; st_data = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        clear_events();
        rd_if.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_events();
        rd_if.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (run !== 1'b1) begin bad++; $display("[TB] FAIL reset_run: got %0d want 1", run); end
        total++; if (rd_if.valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0d want 0", rd_if.valid); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_drop: got %0d want 0", drop_cnt); end
        total++; if ({rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data} !== '0) begin bad++; $display("[TB] FAIL reset_payload: got kind=%0d cyc=%0d idx=%0d data=%0h want all 0", rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data); end
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_single_reg();
        reset_dut();
        repeat (3) tick();
        wb_en = 1'b1; wb_reg = 5'd8; wb_data = 32'd5;
        tick();
        clear_events();
        total++; if (rd_if.valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %0d want 1", rd_if.valid); end
        total++; if (rd_if.kind !== REG) begin bad++; $display("[TB] FAIL single_kind: got %0d want 0", rd_if.kind); end
        total++; if (rd_if.cycle !== 16'd3) begin bad++; $display("[TB] FAIL single_cycle: got %0d want 3", rd_if.cycle); end
        total++; if (rd_if.idx !== 7'd8) begin bad++; $display("[TB] FAIL single_idx: got %0d want 8", rd_if.idx); end
        total++; if (rd_if.data !== 32'd5) begin bad++; $display("[TB] FAIL single_data: got %0d want 5", rd_if.data); end
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL single_level: got %0d want 1", level); end
        rd_if.ready = 1'b1;
        tick();
        rd_if.ready = 1'b0;
        total++; if (rd_if.valid !== 1'b0) begin bad++; $display("[TB] FAIL single_pop_valid: got %0d want 0", rd_if.valid); end
    endtask

    task automatic test_same_cycle();
        while (cyc < 6) tick();
        wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'd7;
        st_en = 1'b1; st_addr = 7'd4; st_data = 32'h2A;
        tick();
        clear_events();
        total++; if (level !== 5'd2) begin bad++; $display("[TB] FAIL pair_level: got %0d want 2", level); end
        total++; if ({rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data} !== {REG, 16'd6, 7'd9, 32'd7}) begin bad++; $display("[TB] FAIL pair_first: got kind=%0d cyc=%0d idx=%0d data=%0h want REG/6/9/7", rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data); end
        rd_if.ready = 1'b1;
        tick();
        total++; if ({rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data} !== {STORE, 16'd6, 7'd4, 32'h2A}) begin bad++; $display("[TB] FAIL pair_second: got kind=%0d cyc=%0d idx=%0d data=%0h want STORE/6/4/2a", rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data); end
        tick();
        rd_if.ready = 1'b0;
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL pair_drained: got %0d want 0", level); end
    endtask

    task automatic test_overflow();
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            wb_en = 1'b1; wb_reg = 5'(i); wb_data = 32'(100 + i);
            tick();
        end
        clear_events();
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL ovf_level: got %0d want 16", level); end
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL ovf_drop: got %0d want 1", drop_cnt); end
        total++; if (rd_if.cycle !== 16'd0 || rd_if.data !== 32'd100) begin bad++; $display("[TB] FAIL ovf_head: got cyc=%0d data=%0d want 0/100", rd_if.cycle, rd_if.data); end
        rd_if.ready = 1'b1;
        tick();
        rd_if.ready = 1'b0;
        total++; if (level !== 5'd15) begin bad++; $display("[TB] FAIL ovf_pop_level: got %0d want 15", level); end
        wb_en = 1'b1; wb_reg = 5'd20; wb_data = 32'hAA;
        st_en = 1'b1; st_addr = 7'd8; st_data = 32'hBB;
        tick();
        clear_events();
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL ovf_pair_level: got %0d want 16", level); end
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("[TB] FAIL ovf_pair_drop: got %0d want 2", drop_cnt); end
        rd_if.ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            total++; if (rd_if.cycle !== 16'(i + 1) || rd_if.data !== 32'(101 + i)) begin bad++; $display("[TB] FAIL ovf_drain_%0d: got cyc=%0d data=%0d want %0d/%0d", i, rd_if.cycle, rd_if.data, i + 1, 101 + i); end
            tick();
        end
        total++; if ({rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data} !== {REG, 16'd18, 7'd20, 32'hAA}) begin bad++; $display("[TB] FAIL ovf_kept_reg: got kind=%0d cyc=%0d idx=%0d data=%0h want REG/18/20/aa", rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data); end
        tick();
        rd_if.ready = 1'b0;
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL ovf_store_dropped: got level %0d want 0", level); end
    endtask

    task automatic test_stop();
        reset_dut();
        pc = PC_VAL;
        rd_if.ready = 1'b1;
        while (cyc < 50) tick();
        total++; if (run !== 1'b1) begin bad++; $display("[TB] FAIL stop_run_before: got %0d want 1", run); end
        wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'h33;
        tick();
        wb_reg = 5'd4; wb_data = 32'h44;
        total++; if (run !== 1'b0) begin bad++; $display("[TB] FAIL stop_run_fall: got %0d want 0", run); end
        total++; if ({rd_if.valid, rd_if.kind, rd_if.cycle, rd_if.data} !== {1'b1, REG, 16'd50, 32'h33}) begin bad++; $display("[TB] FAIL stop_last_event: got v=%0d kind=%0d cyc=%0d data=%0h want 1/REG/50/33", rd_if.valid, rd_if.kind, rd_if.cycle, rd_if.data); end
        tick();
        wb_reg = 5'd5; wb_data = 32'h55;
        total++; if ({rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data} !== {STOP, 16'd50, 7'd0, PC_VAL}) begin bad++; $display("[TB] FAIL stop_marker: got kind=%0d cyc=%0d idx=%0d data=%0h want STOP/50/0/%0h", rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data, PC_VAL); end
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL stop_mark_level: got %0d want 1", level); end
        tick();
        clear_events();
        rd_if.ready = 1'b0;
        total++; if (level !== 5'd0 || rd_if.valid !== 1'b0 || run !== 1'b0) begin bad++; $display("[TB] FAIL stop_done: got level=%0d valid=%0d run=%0d want 0/0/0", level, rd_if.valid, run); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL stop_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_stop_full();
        reset_dut();
        pc = PC_VAL;
        while (cyc < 34) tick();
        for (int i = 0; i < 16; i++) begin
            wb_en = 1'b1; wb_reg = 5'(i + 1); wb_data = 32'(i);
            tick();
        end
        wb_reg = 5'd31; wb_data = 32'hEE;
        tick();
        total++; if (level !== 5'd16 || drop_cnt !== 16'd1 || run !== 1'b0) begin bad++; $display("[TB] FAIL full_at_stop: got level=%0d drop=%0d run=%0d want 16/1/0", level, drop_cnt, run); end
        st_en = 1'b1; st_addr = 7'd1; st_data = 32'd1;
        repeat (3) tick();
        clear_events();
        total++; if (level !== 5'd16 || drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL full_waiting: got level=%0d drop=%0d want 16/1", level, drop_cnt); end
        rd_if.ready = 1'b1;
        tick();
        rd_if.ready = 1'b0;
        total++; if (level !== 5'd16 || drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL full_marker_in: got level=%0d drop=%0d want 16/1", level, drop_cnt); end
        rd_if.ready = 1'b1;
        repeat (15) tick();
        rd_if.ready = 1'b0;
        total++; if ({rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data} !== {STOP, 16'd50, 7'd0, PC_VAL}) begin bad++; $display("[TB] FAIL full_marker_last: got kind=%0d cyc=%0d idx=%0d data=%0h want STOP/50/0/%0h", rd_if.kind, rd_if.cycle, rd_if.idx, rd_if.data, PC_VAL); end
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL full_marker_level: got %0d want 1", level); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        pc = PC_VAL;
        while (cyc < 40) tick();
        for (int i = 0; i < 5; i++) begin
            wb_en = 1'b1; wb_reg = 5'(i + 2); wb_data = 32'(i);
            tick();
        end
        clear_events();
        while (cyc < 53) tick();
        total++; if (level !== 5'd6 || run !== 1'b0) begin bad++; $display("[TB] FAIL arst_pre: got level=%0d run=%0d want 6/0", level, run); end
        rd_if.ready = 1'b1;
        repeat (2) tick();
        #2;
        rst = 1'b0;
        #1;
        total++; if (level !== 5'd0 || rd_if.valid !== 1'b0 || run !== 1'b1) begin bad++; $display("[TB] FAIL arst_immediate: got level=%0d valid=%0d run=%0d want 0/0/1", level, rd_if.valid, run); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL arst_drop: got %0d want 0", drop_cnt); end
        @(negedge clk);
        rst = 1'b1;
        rd_if.ready = 1'b0;
        cyc = 0;
    endtask

    task automatic test_r0_filter();
        reset_dut();
        for (int i = 0; i < 15; i++) begin
            wb_en = 1'b1; wb_reg = 5'(i + 1); wb_data = 32'(i);
            tick();
        end
        wb_reg = 5'd0; wb_data = 32'd9;
        st_en = 1'b1; st_addr = 7'd12; st_data = 32'h77;
        tick();
        clear_events();
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL r0_level: got %0d want 16", level); end
        rd_if.ready = 1'b1;
        repeat (15) tick();
        rd_if.ready = 1'b0;
`ifdef TRACE_R0_FILTER_EN
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("[TB] FAIL r0_drop: got %0d want 0", drop_cnt); end
        total++; if ({rd_if.kind, rd_if.idx, rd_if.data} !== {STORE, 7'd12, 32'h77}) begin bad++; $display("[TB] FAIL r0_last: got kind=%0d idx=%0d data=%0h want STORE/12/77", rd_if.kind, rd_if.idx, rd_if.data); end
`else
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("[TB] FAIL r0_drop: got %0d want 1", drop_cnt); end
        total++; if ({rd_if.kind, rd_if.idx, rd_if.data} !== {REG, 7'd0, 32'd9}) begin bad++; $display("[TB] FAIL r0_last: got kind=%0d idx=%0d data=%0h want REG/0/9", rd_if.kind, rd_if.idx, rd_if.data); end
`endif
    endtask

    initial begin
        pc = PC_VAL;
        test_reset();
        test_single_reg();
        test_same_cycle();
        test_overflow();
        test_stop();
        test_stop_full();
        test_async_reset();
        test_r0_filter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
